eqz_counter: RTL and testbench
==============================

EQZ_COUNTER -- requirements
Module: eqz_counter

Interface
REQ-001 Parameter WIDTH, default 16: counter/data width in bits; legal range 2..32.
REQ-002 Parameter HOLD_DONE, default 0: 0 = done is a one-cycle pulse; 1 = done is held high until the next accepted start.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to load load_val and begin counting; accepted only in IDLE.
REQ-006 load_val  input  WIDTH  initial count, sampled on the accepting edge.
REQ-007 dec  input  1  decrement enable; acted on only in RUN.
REQ-008 abort  input  1  terminate RUN without done.
REQ-009 count  output  WIDTH  current counter register value.
REQ-010 eqz  output  1  high when count == 0, decoded from the count register.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  completion indication, timing per HOLD_DONE.
REQ-013 err  output  1  sticky underflow flag (see Configuration).

Function
REQ-014 FSM states: IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE) when HOLD_DONE = 0.
REQ-015 IDLE: start=1 -> count <= load_val, err <= 0, state <= RUN; otherwise count holds.
REQ-016 RUN, priority order: abort -> IDLE with count held; else eqz -> DONE with dec ignored; else dec -> count <= count - 1; else hold.
REQ-017 DONE -> IDLE unconditionally on the next edge.
REQ-018 HOLD_DONE = 1: the done register sets on entry to DONE and clears on the next accepted start or on reset.
REQ-019 Latency: start is sampled at edge 0 and dec is held high; count reaches 0 after edge N, and DONE is entered at edge N+1. load_val = 0 enters DONE at edge 1.
REQ-020 Decrement is modulo 2^WIDTH arithmetic, but count never wraps: RUN exits at zero before any further decrement.
REQ-021 start in RUN or DONE is ignored; dec in IDLE or DONE is ignored.
REQ-022 When abort and dec arrive in the same cycle, abort wins; count keeps its pre-edge value.
REQ-023 eqz is valid in every state, including IDLE after abort.

Reset
REQ-024 rst=1 asynchronously forces state = IDLE, count = 0, done = 0, err = 0; therefore eqz = 1 and busy = 0.
REQ-025 Reset asserted mid-RUN discards the count; no done is produced.
REQ-026 Reset release is synchronous to clk in the surrounding system; the first start is honoured at the first edge after release.

Configuration
REQ-027 Macro EQZ_COUNTER_UNDERFLOW_EN.
- Defined: dec=1 in RUN with count == 0 sets err; err stays high until the next accepted start or reset.
- Not defined: err is tied to 0 and the underflow condition is silently ignored.

Structure
REQ-028 Package eqz_counter_pkg holds the state enum typedef (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-029 Sub-module eqz_detect #(WIDTH) is the combinational zero detector that drives eqz from count; it is instantiated once.

Verification
REQ-030 rst pulsed mid-cycle while clk is stopped -> count = 0, eqz = 1, busy = 0, done = 0 immediately, before any clock edge.
REQ-031 start with load_val = 5, dec held high -> count 5,4,3,2,1,0; DONE at edge 6; done high for exactly one cycle; busy low afterwards.
REQ-032 start with load_val = 0 -> busy for one cycle; done at edge 1; count stays 0.
REQ-033 load_val = 3, dec high, abort and dec together at count = 2 -> IDLE, count = 2, no done; a start during RUN does not reload.
REQ-034 With EQZ_COUNTER_UNDERFLOW_EN defined: load_val = 1, dec high -> err = 1 at the DONE edge and stays 1 until the next start. Without the macro: err = 0 throughout.
REQ-035 WIDTH = 4, HOLD_DONE = 1, load_val = 15 -> DONE at edge 16; done stays high until the next start is accepted.

Source files
------------

// File: rtl/eqz_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eqz_counter_pkg
// Purpose  : Shared types and constants for the eqz_counter block:
//            the control FSM state encoding and the default data width.
// Revision : 1.0 - initial release
// ============================================================================
package eqz_counter_pkg;

  // Default counter/data width in bits (legal range 2..32)
  localparam int unsigned C_WIDTH_DEFAULT = 16;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : eqz_counter_pkg
`default_nettype wire

// File: rtl/eqz_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : eqz_counter_if
// Purpose  : Control/status bundle of the eqz_counter block.
// Ports    : start    - request to load load_val and begin counting
//            load_val - initial count (WIDTH bits)
//            dec      - decrement enable
//            abort    - terminate a run without completion
//            count    - current counter value (WIDTH bits)
//            eqz      - count == 0
//            busy     - counter is running
//            done     - completion indication
//            err      - sticky underflow flag
// Modports : master (drives requests), slave (the counter itself)
// Revision : 1.0 - initial release
// ============================================================================
interface eqz_counter_if
  import eqz_counter_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             dec;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             eqz;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, load_val, dec, abort,
    input  count, eqz, busy, done, err
  );

  modport slave (
    input  start, load_val, dec, abort,
    output count, eqz, busy, done, err
  );

endinterface : eqz_counter_if
`default_nettype wire

// File: rtl/eqz_detect.sv
`default_nettype none
// ============================================================================
// Module   : eqz_detect
// Purpose  : Combinational zero detector for the counter register.
// Ports    : i_count - value to test (WIDTH bits)
//            o_eqz   - high when i_count is all zeros
// Revision : 1.0 - initial release
// ============================================================================
module eqz_detect
  import eqz_counter_pkg::*;
#(
  parameter int unsigned WIDTH = C_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_count,
  output logic             o_eqz
);

  assign o_eqz = (i_count == '0);

endmodule : eqz_detect
`default_nettype wire

// File: rtl/eqz_counter.sv
`default_nettype none
// ============================================================================
// Module   : eqz_counter
// Purpose  : Loadable down-counter with zero detect. A start in IDLE loads
//            the count and enters RUN; in RUN the count decrements on dec
//            until it reaches zero, then DONE is visited for one cycle.
//            abort returns to IDLE holding the count.
// Ports    : clk - clock, rising edge
//            rst - asynchronous active-high reset
//            bus - eqz_counter_if.slave (start/load_val/dec/abort in,
//                  count/eqz/busy/done/err out)
// Params   : WIDTH     - counter width (2..32)
//            HOLD_DONE - 0: done is a one-cycle pulse
//                        1: done held until the next accepted start
// Macro    : EQZ_COUNTER_UNDERFLOW_EN - when defined, dec in RUN at count 0
//            sets the sticky err flag; otherwise err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module eqz_counter
  import eqz_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = C_WIDTH_DEFAULT,
  parameter bit          HOLD_DONE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  eqz_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_eqz;
  logic             w_accept;
  logic             w_err;

  eqz_detect #(
    .WIDTH (WIDTH)
  ) u_eqz_detect (
    .i_count (r_count),
    .o_eqz   (w_eqz)
  );

  // Next-state / next-count decode. In RUN, abort beats the zero exit,
  // which beats dec, so the count can never wrap below zero.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_count_nxt = bus.load_val;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_state_nxt = IDLE;
        end else if (w_eqz) begin
          w_state_nxt = DONE;
        end else if (bus.dec) begin
          w_count_nxt = r_count - c_one;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

`ifdef EQZ_COUNTER_UNDERFLOW_EN
  logic w_underflow;
  logic r_err;

  // A dec request while RUN already sits at zero is an underflow attempt.
  assign w_underflow = (r_state == RUN) && bus.dec && w_eqz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_underflow) begin
      r_err <= 1'b1;
    end
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  generate
    if (HOLD_DONE) begin : g_done_hold
      logic r_done;

      // Set together with the DONE state so done rises on the same edge
      // as in pulse mode, then stays up through IDLE until a new start.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_done <= 1'b0;
        end else if (w_accept) begin
          r_done <= 1'b0;
        end else if (w_state_nxt == DONE) begin
          r_done <= 1'b1;
        end
      end

      assign bus.done = r_done;
    end else begin : g_done_pulse
      assign bus.done = (r_state == DONE);
    end
  endgenerate

  assign bus.count = r_count;
  assign bus.eqz   = w_eqz;
  assign bus.busy  = (r_state == RUN);
  assign bus.err   = w_err;

endmodule : eqz_counter
`default_nettype wire

// File: tb/tb_eqz_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eqz_counter
// Purpose  : Self-checking bench for eqz_counter. Two instances:
//            dut0 WIDTH=16 HOLD_DONE=0, dut1 WIDTH=4 HOLD_DONE=1.
//            Directed stimulus pushes the hand-computed post-edge state into
//            a per-DUT queue; monitors pop and compare after each edge.
// Macro    : EQZ_COUNTER_UNDERFLOW_EN selects the expected err behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eqz_counter;
  import eqz_counter_pkg::*;

`ifdef EQZ_COUNTER_UNDERFLOW_EN
  localparam bit c_uf = 1'b1;
`else
  localparam bit c_uf = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic clk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string nm;
    int    cnt;
    bit    eqz;
    bit    busy;
    bit    done;
    bit    err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  eqz_counter_if #(.WIDTH(16)) if0 ();
  eqz_counter_if #(.WIDTH(4))  if1 ();

  eqz_counter #(.WIDTH(16), .HOLD_DONE(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  eqz_counter #(.WIDTH(4), .HOLD_DONE(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Gated clock so reset can be exercised with no edges present
  always #5 if (clk_en) clk = ~clk;

  task automatic check_one(input string nm, input string fld,
                           input logic [31:0] act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, expv, $time);
    end
  endtask

  task automatic check_all(input exp_t e, input logic [31:0] c,
                           input logic eq, input logic bs,
                           input logic dn, input logic er);
    check_one(e.nm, "count", c,            e.cnt);
    check_one(e.nm, "eqz",   {31'd0, eq},  int'(e.eqz));
    check_one(e.nm, "busy",  {31'd0, bs},  int'(e.busy));
    check_one(e.nm, "done",  {31'd0, dn},  int'(e.done));
    check_one(e.nm, "err",   {31'd0, er},  int'(e.err));
  endtask

  // Monitors: compare whatever expectation is pending after each edge
  always @(posedge clk) begin : mon0
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_all(e, {16'd0, if0.count}, if0.eqz, if0.busy, if0.done, if0.err);
    end
  end

  always @(posedge clk) begin : mon1
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check_all(e, {28'd0, if1.count}, if1.eqz, if1.busy, if1.done, if1.err);
    end
  end

  task automatic idle_inputs();
    if0.start = 1'b0; if0.load_val = '0; if0.dec = 1'b0; if0.abort = 1'b0;
    if1.start = 1'b0; if1.load_val = '0; if1.dec = 1'b0; if1.abort = 1'b0;
  endtask

  function automatic exp_t mk(input string nm, input int c, input bit eq,
                              input bit bs, input bit dn, input bit er);
    exp_t e;
    e.nm = nm; e.cnt = c; e.eqz = eq; e.busy = bs; e.done = dn; e.err = er;
    return e;
  endfunction

  // One clock of stimulus to DUT d plus the expected state after the edge
  task automatic cyc(input int d, input bit st, input int lv, input bit dc,
                     input bit ab, input string nm, input int ec, input bit eeq,
                     input bit eb, input bit ed, input bit eer);
    int v;
    v = lv;
    @(negedge clk);
    idle_inputs();
    if (d == 0) begin
      if0.start = st; if0.load_val = v[15:0]; if0.dec = dc; if0.abort = ab;
      q0.push_back(mk(nm, ec, eeq, eb, ed, eer));
    end else begin
      if1.start = st; if1.load_val = v[3:0]; if1.dec = dc; if1.abort = ab;
      q1.push_back(mk(nm, ec, eeq, eb, ed, eer));
    end
  endtask

  initial begin
    idle_inputs();

    // Asynchronous reset with no clock running
    #1 rst = 1'b1;
    #2;
    check_all(mk("rst_async0", 0, 1, 0, 0, 0), {16'd0, if0.count},
              if0.eqz, if0.busy, if0.done, if0.err);
    check_all(mk("rst_async1", 0, 1, 0, 0, 0), {28'd0, if1.count},
              if1.eqz, if1.busy, if1.done, if1.err);
    #1 rst = 1'b0;
    #8 clk_en = 1'b1;

    // A: load 5, dec held -> 5..0, DONE at edge 6, one-cycle done
    cyc(0, 1, 5, 1, 0, "A_load", 5, 0, 1, 0, 0);
    for (int k = 4; k >= 0; k--)
      cyc(0, 0, 0, 1, 0, "A_dec", k, (k == 0), 1, 0, 0);
    cyc(0, 0, 0, 1, 0, "A_done", 0, 1, 0, 1, c_uf);
    cyc(0, 0, 0, 0, 0, "A_idle", 0, 1, 0, 0, c_uf);

    // B: load 0 -> one busy cycle, done at edge 1
    cyc(0, 1, 0, 0, 0, "B_load", 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, "B_done", 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, "B_idle", 0, 1, 0, 0, 0);

    // C: start in RUN ignored; abort+dec at count 2 holds count
    cyc(0, 1, 3, 1, 0, "C_load", 3, 0, 1, 0, 0);
    cyc(0, 1, 9, 1, 0, "C_noreload", 2, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, "C_abort", 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, "C_idle", 2, 0, 0, 0, 0);

    // D: underflow attempt at zero; dec in IDLE ignored; start clears err
    cyc(0, 1, 1, 1, 0, "D_load", 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, "D_zero", 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, "D_done", 0, 1, 0, 1, c_uf);
    cyc(0, 0, 0, 1, 0, "D_idle", 0, 1, 0, 0, c_uf);
    cyc(0, 0, 0, 1, 0, "D_idle_dec", 0, 1, 0, 0, c_uf);
    cyc(0, 1, 2, 0, 0, "D_restart", 2, 0, 1, 0, 0);

    // E: reset mid-RUN with the clock stopped, then start on first edge
    cyc(0, 0, 0, 1, 0, "E_dec", 1, 0, 1, 0, 0);
    @(negedge clk);
    clk_en = 1'b0;
    idle_inputs();
    #12 rst = 1'b1;
    #1;
    check_all(mk("E_rst", 0, 1, 0, 0, 0), {16'd0, if0.count},
              if0.eqz, if0.busy, if0.done, if0.err);
    #1 rst = 1'b0;
    if0.start = 1'b1; if0.load_val = 16'd7;
    q0.push_back(mk("E_first", 7, 0, 1, 0, 0));
    clk_en = 1'b1;
    cyc(0, 0, 0, 0, 1, "E_abort", 7, 0, 0, 0, 0);

    // F: WIDTH 4, HOLD_DONE 1, load 15 -> DONE at edge 16, done held
    cyc(1, 1, 15, 1, 0, "F_load", 15, 0, 1, 0, 0);
    for (int k = 14; k >= 0; k--)
      cyc(1, 0, 0, 1, 0, "F_dec", k, (k == 0), 1, 0, 0);
    cyc(1, 0, 0, 1, 0, "F_done", 0, 1, 0, 1, c_uf);
    cyc(1, 0, 0, 0, 0, "F_hold", 0, 1, 0, 1, c_uf);
    cyc(1, 0, 0, 0, 0, "F_hold2", 0, 1, 0, 1, c_uf);
    cyc(1, 1, 3, 0, 0, "F_restart", 3, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, "F_abort", 3, 0, 0, 0, 0);

    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_errors++;
      $display("FAIL drain: pending q0=%0d q1=%0d, expected 0", q0.size(), q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_errors++;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule : tb_eqz_counter
`default_nettype wire
